input_conditioner: RTL

//   Multi-channel button conditioner; parametrised successor to the per-button debouncer.

---
 rtl/input_conditioner.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Multi-channel button conditioner: 2-flop synchroniser, tick-based debounce,
// press/release pulses and optional per-channel hold-to-auto-repeat.
module input_conditioner #(
  parameter int unsigned         CHANNELS      = 2,
  parameter int unsigned         STABLE_TICKS  = 4,
  parameter int unsigned         REPEAT_DELAY  = 12,
  parameter int unsigned         REPEAT_PERIOD = 4,
  parameter logic [CHANNELS-1:0] REPEAT_MASK   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_tick,
  input  logic [CHANNELS-1:0] i_buttons,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_press,
  output logic [CHANNELS-1:0] o_release,
  output logic [CHANNELS-1:0] o_repeat,
  output logic                o_any
);

  localparam int unsigned   DBW     = $clog2(STABLE_TICKS + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_HOLD,
    RS_RPT
  } rpt_state_e;

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] level_q, press_q, release_q;
  logic                any_q;
  logic [DBW-1:0]      db_q [CHANNELS];

  logic [CHANNELS-1:0] differ_d, accept_d, press_d, release_d;

  // Two-stage synchroniser for the raw pad inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_buttons;
      sync2_q <= sync1_q;
    end
  end

  // Detect the tick that completes a run of disagreeing samples.
  always_comb begin
    differ_d  = '0;
    accept_d  = '0;
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      differ_d[i]  = sync2_q[i] ^ level_q[i];
      accept_d[i]  = i_tick & differ_d[i] & (db_q[i] == DB_LAST);
      press_d[i]   = accept_d[i] & ~level_q[i];
      release_d[i] = accept_d[i] & level_q[i];
    end
  end

  // Debounce counters and accepted levels; any agreeing cycle restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        db_q[i] <= '0;
      end
    end else begin
      level_q <= level_q ^ accept_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!differ_d[i]) begin
          db_q[i] <= '0;
        end else if (i_tick) begin
          if (accept_d[i]) begin
            db_q[i] <= '0;
          end else begin
            db_q[i] <= db_q[i] + DBW'(1);
          end
        end
      end
    end
  end

  // Edge pulses registered alongside the level so they mark its first new cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= |press_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    if (REPEAT_MASK[g]) begin : g_rpt
      localparam int unsigned    RMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                           : REPEAT_PERIOD;
      localparam int unsigned    RPW      = $clog2(RMAX + 1);
      localparam logic [RPW-1:0] DLY_LAST = RPW'(REPEAT_DELAY - 1);
      localparam logic [RPW-1:0] PER_LAST = RPW'(REPEAT_PERIOD - 1);

      rpt_state_e     st_q;
      logic [RPW-1:0] rp_q;
      logic           rep_q;

      // Auto-repeat sequencer: initial delay after press, then periodic pulses.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          st_q  <= RS_IDLE;
          rp_q  <= '0;
          rep_q <= 1'b0;
        end else begin
          rep_q <= 1'b0;
          case (st_q)
            RS_IDLE: begin
              if (press_d[g]) begin
                st_q <= RS_HOLD;
                rp_q <= '0;
              end
            end
            RS_HOLD: begin
              if (release_d[g]) begin
                st_q <= RS_IDLE;
                rp_q <= '0;
              end else if (i_tick) begin
                if (rp_q == DLY_LAST) begin
                  rep_q <= 1'b1;
                  rp_q  <= '0;
                  st_q  <= RS_RPT;
                end else begin
                  rp_q <= rp_q + RPW'(1);
                end
              end
            end
            RS_RPT: begin
              if (release_d[g]) begin
                st_q <= RS_IDLE;
                rp_q <= '0;
              end else if (i_tick) begin
                if (rp_q == PER_LAST) begin
                  rep_q <= 1'b1;
                  rp_q  <= '0;
                end else begin
                  rp_q <= rp_q + RPW'(1);
                end
              end
            end
            default: begin
              st_q <= RS_IDLE;
              rp_q <= '0;
            end
          endcase
        end
      end

      assign o_repeat[g] = rep_q;
    end else begin : g_norpt
      assign o_repeat[g] = 1'b0;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_any     = any_q;

endmodule
